// File: rtl/dispatcher_pkg.sv
// Shared types and geometry for the fetch sequencer and its exponent unpacker.
package dispatcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXP  = 2'd1,
    ST_MAN  = 2'd2,
    ST_DONE = 2'd3
  } fetch_state_e;

  localparam int EXP_LINES  = 16;
  localparam int MAN_LINES  = 512;
  localparam int BEAT_W     = 11;
  // k = {packed line index, byte within line}
  localparam int EXP_IDX_W  = 4;
  localparam int BYTE_SEL_W = 5;
  localparam int UNPACK_W   = EXP_IDX_W + BYTE_SEL_W;

endpackage

// File: rtl/exp_unpacker.sv
// Walks k over every packed exponent byte once per fetch and emits one aligned
// write per cycle to the side chosen for the current fetch.
module exp_unpacker #(
  parameter int DATA_WIDTH = 256
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  input  logic                  i_target,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic [3:0]            o_rd_addr,
  output logic [8:0]            o_wr_addr,
  output logic [7:0]            o_wr_data,
  output logic                  o_left_wr_en,
  output logic                  o_right_wr_en,
  output logic                  o_done
);
  import dispatcher_pkg::*;

  logic                   arm_q;
  logic                   active_q;
  logic [UNPACK_W-1:0]    k_q;
  logic                   done_q;
  logic [UNPACK_W-1:0]    aw_addr_q;
  logic [7:0]             aw_data_q;
  logic                   left_en_q;
  logic                   right_en_q;
  logic [BYTE_SEL_W+2:0]  bit_lo;
  logic [7:0]             byte_sel;

  assign bit_lo    = {k_q[BYTE_SEL_W-1:0], 3'b000};
  assign byte_sel  = i_rd_data[bit_lo +: 8];
  assign o_rd_addr = k_q[UNPACK_W-1:BYTE_SEL_W];

  // arm_q adds the second cycle of delay between MAN entry and k=0
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      arm_q      <= 1'b0;
      active_q   <= 1'b0;
      k_q        <= '0;
      done_q     <= 1'b0;
      aw_addr_q  <= '0;
      aw_data_q  <= '0;
      left_en_q  <= 1'b0;
      right_en_q <= 1'b0;
    end else begin
      arm_q      <= i_start;
      left_en_q  <= active_q & ~i_target;
      right_en_q <= active_q & i_target;
      if (active_q) begin
        aw_addr_q <= k_q;
        aw_data_q <= byte_sel;
      end
      if (arm_q) begin
        active_q <= 1'b1;
        k_q      <= '0;
      end else if (active_q) begin
        k_q <= k_q + UNPACK_W'(1);
        if (k_q == '1) active_q <= 1'b0;
      end
      if (i_start) done_q <= 1'b0;
      else if (active_q && k_q == '1) done_q <= 1'b1;
    end
  end

  assign o_wr_addr     = aw_addr_q;
  assign o_wr_data     = aw_data_q;
  assign o_left_wr_en  = left_en_q;
  assign o_right_wr_en = right_en_q;
  assign o_done        = done_q;

endmodule

// File: rtl/dispatcher_fetch_sequencer.sv
// Accepts one fetch at a time, streams exponent then mantissa lines into the
// line buffer, and drives the exponent unpacker once the exponent lines are in.
module dispatcher_fetch_sequencer #(
  parameter int DATA_WIDTH = 256,
  parameter int EXP_LINES  = dispatcher_pkg::EXP_LINES,
  parameter int MAN_LINES  = dispatcher_pkg::MAN_LINES
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_fetch_valid,
  input  logic                  i_fetch_target,
  output logic                  o_fetch_ready,
  input  logic [DATA_WIDTH-1:0] i_line_data,
  input  logic                  i_line_valid,
  output logic                  o_line_ready,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic [10:0]           o_wr_addr,
  output logic                  o_wr_en,
  output logic                  o_wr_target,
  output logic [3:0]            o_exp_packed_rd_addr,
  output logic                  o_exp_packed_rd_target,
  input  logic [DATA_WIDTH-1:0] i_exp_packed_rd_data,
  output logic [8:0]            o_left_exp_aligned_wr_addr,
  output logic [7:0]            o_left_exp_aligned_wr_data,
  output logic                  o_left_exp_aligned_wr_en,
  output logic [8:0]            o_right_exp_aligned_wr_addr,
  output logic [7:0]            o_right_exp_aligned_wr_data,
  output logic                  o_right_exp_aligned_wr_en,
  output logic                  o_busy,
  output logic                  o_done
);
  import dispatcher_pkg::*;

  localparam logic [BEAT_W-1:0] LAST_EXP = BEAT_W'(EXP_LINES - 1);
  localparam logic [BEAT_W-1:0] TOTAL    = BEAT_W'(EXP_LINES + MAN_LINES);

  fetch_state_e          state_q;
  logic [BEAT_W-1:0]     beat_q;
  logic                  target_q;
  logic                  start_q;
  logic                  busy_q;
  logic                  ready_q;
  logic                  done_q;
  logic                  wr_en_q;
  logic [BEAT_W-1:0]     wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  wr_target_q;
  logic                  line_ready;
  logic                  line_acc;
  logic                  fetch_acc;
  logic                  unp_done;
  logic [8:0]            aw_addr;
  logic [7:0]            aw_data;

  // beat_q < TOTAL is the same as "mantissa count below MAN_LINES" in MAN
  assign line_ready = (state_q == ST_EXP) || (state_q == ST_MAN && beat_q < TOTAL);
  assign line_acc   = i_line_valid & line_ready;
  assign fetch_acc  = i_fetch_valid & ready_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= ST_IDLE;
      beat_q   <= '0;
      target_q <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (fetch_acc) begin
            target_q <= i_fetch_target;
            beat_q   <= '0;
            state_q  <= ST_EXP;
            busy_q   <= 1'b1;
            ready_q  <= 1'b0;
          end
        end
        ST_EXP: begin
          if (line_acc) begin
            beat_q <= beat_q + BEAT_W'(1);
            if (beat_q == LAST_EXP) begin
              state_q <= ST_MAN;
              start_q <= 1'b1;
            end
          end
        end
        ST_MAN: begin
          if (line_acc) beat_q <= beat_q + BEAT_W'(1);
          // beat_q == TOTAL: the final mantissa write is on the outputs now
          if (beat_q == TOTAL && unp_done) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_target_q <= 1'b0;
    end else begin
      wr_en_q <= line_acc;
      if (line_acc) begin
        wr_addr_q   <= beat_q;
        wr_data_q   <= i_line_data;
        wr_target_q <= target_q;
      end
    end
  end

  exp_unpacker #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_exp_unpacker (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_start      (start_q),
    .i_target     (target_q),
    .i_rd_data    (i_exp_packed_rd_data),
    .o_rd_addr    (o_exp_packed_rd_addr),
    .o_wr_addr    (aw_addr),
    .o_wr_data    (aw_data),
    .o_left_wr_en (o_left_exp_aligned_wr_en),
    .o_right_wr_en(o_right_exp_aligned_wr_en),
    .o_done       (unp_done)
  );

  assign o_fetch_ready               = ready_q;
  assign o_line_ready                = line_ready;
  assign o_wr_data                   = wr_data_q;
  assign o_wr_addr                   = wr_addr_q;
  assign o_wr_en                     = wr_en_q;
  assign o_wr_target                 = wr_target_q;
  assign o_exp_packed_rd_target      = target_q;
  assign o_left_exp_aligned_wr_addr  = aw_addr;
  assign o_left_exp_aligned_wr_data  = aw_data;
  assign o_right_exp_aligned_wr_addr = aw_addr;
  assign o_right_exp_aligned_wr_data = aw_data;
  assign o_busy                      = busy_q;
  assign o_done                      = done_q;

endmodule

// File: tb/tb_dispatcher_fetch_sequencer.sv
// Directed bench for dispatcher_fetch_sequencer: full fetches on both sides,
// stalled mantissa stream, held fetch request, mid-fetch reset and overrun beats.
module tb_dispatcher_fetch_sequencer;
  localparam int DW = 256;

  logic          i_clk = 1'b0;
  logic          i_reset_n;
  logic          i_fetch_valid, i_fetch_target, o_fetch_ready;
  logic [DW-1:0] i_line_data;
  logic          i_line_valid, o_line_ready;
  logic [DW-1:0] o_wr_data;
  logic [10:0]   o_wr_addr;
  logic          o_wr_en, o_wr_target;
  logic [3:0]    o_exp_packed_rd_addr;
  logic          o_exp_packed_rd_target;
  logic [DW-1:0] i_exp_packed_rd_data;
  logic [8:0]    o_left_exp_aligned_wr_addr, o_right_exp_aligned_wr_addr;
  logic [7:0]    o_left_exp_aligned_wr_data, o_right_exp_aligned_wr_data;
  logic          o_left_exp_aligned_wr_en, o_right_exp_aligned_wr_en;
  logic          o_busy, o_done;

  dispatcher_fetch_sequencer dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_fetch_valid(i_fetch_valid), .i_fetch_target(i_fetch_target), .o_fetch_ready(o_fetch_ready),
    .i_line_data(i_line_data), .i_line_valid(i_line_valid), .o_line_ready(o_line_ready),
    .o_wr_data(o_wr_data), .o_wr_addr(o_wr_addr), .o_wr_en(o_wr_en), .o_wr_target(o_wr_target),
    .o_exp_packed_rd_addr(o_exp_packed_rd_addr), .o_exp_packed_rd_target(o_exp_packed_rd_target),
    .i_exp_packed_rd_data(i_exp_packed_rd_data),
    .o_left_exp_aligned_wr_addr(o_left_exp_aligned_wr_addr),
    .o_left_exp_aligned_wr_data(o_left_exp_aligned_wr_data),
    .o_left_exp_aligned_wr_en(o_left_exp_aligned_wr_en),
    .o_right_exp_aligned_wr_addr(o_right_exp_aligned_wr_addr),
    .o_right_exp_aligned_wr_data(o_right_exp_aligned_wr_data),
    .o_right_exp_aligned_wr_en(o_right_exp_aligned_wr_en),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {int cyc; int addr; logic [DW-1:0] data; logic tgt;} wr_rec_t;
  typedef struct {int cyc; int addr; logic [7:0] data;} aw_rec_t;

  wr_rec_t wr_q[$];
  aw_rec_t left_q[$];
  aw_rec_t right_q[$];
  int      done_q[$];
  int      cyc = 0;
  int      sent = 0;
  int      n_cmp = 0;
  int      n_bad = 0;

  logic [DW-1:0] pmem [0:1][0:15];

  // Packed-exponent content: byte k holds k (left) or k^0x55 (right), with two marker bytes.
  function automatic logic [7:0] exp_byte(input logic side, input int k);
    if (k == 127) return 8'hA5;
    if (k == 480) return 8'h3C;
    return k[7:0] ^ (side ? 8'h55 : 8'h00);
  endfunction

  assign i_exp_packed_rd_data = pmem[o_exp_packed_rd_target][o_exp_packed_rd_addr];

  always @(posedge i_clk) begin
    cyc = cyc + 1;
    #1;
    if (o_wr_en) wr_q.push_back('{cyc, int'(o_wr_addr), o_wr_data, o_wr_target});
    if (o_left_exp_aligned_wr_en)
      left_q.push_back('{cyc, int'(o_left_exp_aligned_wr_addr), o_left_exp_aligned_wr_data});
    if (o_right_exp_aligned_wr_en)
      right_q.push_back('{cyc, int'(o_right_exp_aligned_wr_addr), o_right_exp_aligned_wr_data});
    if (o_done) done_q.push_back(cyc);
  end

  task automatic step();
    logic acc;
    acc = i_line_valid & o_line_ready;
    @(posedge i_clk); #1;
    if (acc) sent++;
    i_line_data = DW'(sent);
  endtask

  task automatic clear_logs();
    wr_q.delete(); left_q.delete(); right_q.delete(); done_q.delete();
    sent = 0;
    i_line_data = '0;
  endtask

  task automatic pulse_reset();
    #2 i_reset_n = 1'b0;
    @(posedge i_clk); @(posedge i_clk); #1;
    i_reset_n = 1'b1;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    n_cmp++; if (o_fetch_ready !== 1'b1) begin n_bad++; $display("FAIL reset_fetch_ready got %b want 1", o_fetch_ready); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", o_busy); end
    n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", o_done); end
    n_cmp++; if (o_line_ready !== 1'b0) begin n_bad++; $display("FAIL reset_line_ready got %b want 0", o_line_ready); end
    n_cmp++; if ({o_wr_en, o_left_exp_aligned_wr_en, o_right_exp_aligned_wr_en} !== 3'b000) begin
      n_bad++; $display("FAIL reset_enables got %b want 000", {o_wr_en, o_left_exp_aligned_wr_en, o_right_exp_aligned_wr_en});
    end
    n_cmp++; if ({o_wr_addr, o_exp_packed_rd_addr, o_left_exp_aligned_wr_addr, o_wr_target, o_exp_packed_rd_target} !== '0) begin
      n_bad++; $display("FAIL reset_addrs wr %0d rd %0d aw %0d tgt %b/%b want all 0",
                        o_wr_addr, o_exp_packed_rd_addr, o_left_exp_aligned_wr_addr, o_wr_target, o_exp_packed_rd_target);
    end
    i_reset_n = 1'b1;
    step();
  endtask

  task automatic test_left_fetch();
    int  errs, last;
    bit  got_done, lr_checked;
    clear_logs();
    i_line_valid = 1'b1;
    i_fetch_target = 1'b0;
    i_fetch_valid = 1'b1;
    step();
    i_fetch_valid = 1'b0;
    n_cmp++; if (o_busy !== 1'b1 || o_fetch_ready !== 1'b0) begin
      n_bad++; $display("FAIL left_accept busy %b ready %b want 1 0", o_busy, o_fetch_ready);
    end
    got_done = 0; lr_checked = 0;
    for (int i = 0; i < 3000 && !got_done; i++) begin
      step();
      if (sent == 528 && !lr_checked && !o_done) begin
        lr_checked = 1;
        n_cmp++; if (o_line_ready !== 1'b0) begin n_bad++; $display("FAIL left_overrun_ready got %b want 0", o_line_ready); end
      end
      if (o_done) got_done = 1;
    end
    n_cmp++; if (!got_done) begin n_bad++; $display("FAIL left_timeout done not seen within 3000 cycles"); end
    repeat (4) step();
    i_line_valid = 1'b0;
    n_cmp++; if (wr_q.size() != 528) begin n_bad++; $display("FAIL left_wr_count got %0d want 528", wr_q.size()); end
    errs = 0;
    foreach (wr_q[i]) if (wr_q[i].addr != i || wr_q[i].data !== DW'(i) || wr_q[i].tgt !== 1'b0) begin
      if (errs == 0) $display("FAIL left_wr_seq idx %0d got addr %0d data %0h tgt %b want %0d %0h 0",
                              i, wr_q[i].addr, wr_q[i].data, wr_q[i].tgt, i, i);
      errs++;
    end
    n_cmp++; if (errs != 0) n_bad++;
    n_cmp++; if (left_q.size() != 512) begin n_bad++; $display("FAIL left_aw_count got %0d want 512", left_q.size()); end
    errs = 0;
    foreach (left_q[i]) if (left_q[i].addr != i || left_q[i].data !== exp_byte(1'b0, i)) begin
      if (errs == 0) $display("FAIL left_aw_seq idx %0d got addr %0d data %0h want %0d %0h",
                              i, left_q[i].addr, left_q[i].data, i, exp_byte(1'b0, i));
      errs++;
    end
    n_cmp++; if (errs != 0) n_bad++;
    n_cmp++; if (right_q.size() != 0) begin n_bad++; $display("FAIL left_no_right got %0d right writes want 0", right_q.size()); end
    if (left_q.size() == 512) begin
      n_cmp++; if (left_q[127].addr != 127 || left_q[127].data !== 8'hA5) begin
        n_bad++; $display("FAIL marker_127 got addr %0d data %0h want 127 a5", left_q[127].addr, left_q[127].data);
      end
      n_cmp++; if (left_q[480].addr != 480 || left_q[480].data !== 8'h3C) begin
        n_bad++; $display("FAIL marker_480 got addr %0d data %0h want 480 3c", left_q[480].addr, left_q[480].data);
      end
    end
    n_cmp++; if (done_q.size() != 1) begin n_bad++; $display("FAIL left_done_count got %0d want 1", done_q.size()); end
    if (done_q.size() >= 1 && wr_q.size() > 0 && left_q.size() > 0) begin
      last = (wr_q[$].cyc > left_q[$].cyc) ? wr_q[$].cyc : left_q[$].cyc;
      n_cmp++; if (done_q[0] != last + 1) begin
        n_bad++; $display("FAIL left_done_timing got cycle %0d want %0d", done_q[0], last + 1);
      end
    end
  endtask

  task automatic test_right_stalled();
    int errs;
    bit got_done;
    clear_logs();
    i_line_valid = 1'b1;
    i_fetch_target = 1'b1;
    i_fetch_valid = 1'b1;
    step();
    i_fetch_valid = 1'b0;
    got_done = 0;
    for (int i = 0; i < 3000 && !got_done; i++) begin
      i_line_valid = (sent < 16) ? 1'b1 : ~i_line_valid;
      step();
      if (o_done) got_done = 1;
    end
    n_cmp++; if (!got_done) begin n_bad++; $display("FAIL right_timeout done not seen within 3000 cycles"); end
    repeat (2) step();
    i_line_valid = 1'b0;
    n_cmp++; if (right_q.size() != 512) begin n_bad++; $display("FAIL right_aw_count got %0d want 512", right_q.size()); end
    errs = 0;
    foreach (right_q[i]) if (right_q[i].addr != i || right_q[i].data !== exp_byte(1'b1, i)) begin
      if (errs == 0) $display("FAIL right_aw_seq idx %0d got addr %0d data %0h want %0d %0h",
                              i, right_q[i].addr, right_q[i].data, i, exp_byte(1'b1, i));
      errs++;
    end
    n_cmp++; if (errs != 0) n_bad++;
    if (right_q.size() == 512) begin
      n_cmp++; if (right_q[511].cyc - right_q[0].cyc != 511) begin
        n_bad++; $display("FAIL right_aw_span got %0d cycles want 511", right_q[511].cyc - right_q[0].cyc);
      end
    end
    n_cmp++; if (left_q.size() != 0) begin n_bad++; $display("FAIL right_no_left got %0d left writes want 0", left_q.size()); end
    n_cmp++; if (wr_q.size() != 528) begin n_bad++; $display("FAIL right_wr_count got %0d want 528", wr_q.size()); end
    errs = 0;
    foreach (wr_q[i]) begin
      if (wr_q[i].addr != i || wr_q[i].data !== DW'(i) || wr_q[i].tgt !== 1'b1) errs++;
      if (i > 16 && wr_q[i].cyc - wr_q[i-1].cyc < 2) errs++;
    end
    n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL right_wr_gapped got %0d bad writes want 0", errs); end
    if (wr_q.size() == 528 && done_q.size() == 1) begin
      n_cmp++; if (done_q[0] != wr_q[527].cyc + 1) begin
        n_bad++; $display("FAIL right_done_timing got cycle %0d want %0d", done_q[0], wr_q[527].cyc + 1);
      end
    end else begin
      n_cmp++; n_bad++; $display("FAIL right_done_count got %0d want 1", done_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int  errs;
    bit  got_done;
    clear_logs();
    i_line_valid = 1'b1;
    i_fetch_target = 1'b0;
    i_fetch_valid = 1'b1;
    step();
    got_done = 0; errs = 0;
    for (int i = 0; i < 3000 && !got_done; i++) begin
      step();
      if (o_done) got_done = 1;
      if (o_fetch_ready !== 1'b0) errs++;
    end
    n_cmp++; if (!got_done || errs != 0) begin
      n_bad++; $display("FAIL b2b_holdoff done %0d ready-high cycles %0d want 1 0", got_done, errs);
    end
    step();
    n_cmp++; if (o_fetch_ready !== 1'b1 || o_busy !== 1'b0) begin
      n_bad++; $display("FAIL b2b_idle ready %b busy %b want 1 0", o_fetch_ready, o_busy);
    end
    clear_logs();
    step();
    n_cmp++; if (o_busy !== 1'b1 || o_fetch_ready !== 1'b0) begin
      n_bad++; $display("FAIL b2b_second_accept busy %b ready %b want 1 0", o_busy, o_fetch_ready);
    end
    i_fetch_valid = 1'b0;
    repeat (4) step();
    n_cmp++; if (wr_q.size() == 0 || wr_q[0].addr != 0 || wr_q[0].data !== '0) begin
      n_bad++; $display("FAIL b2b_restart writes %0d first addr %0d want >0 and 0",
                        wr_q.size(), (wr_q.size() > 0) ? wr_q[0].addr : -1);
    end
    i_line_valid = 1'b0;
    pulse_reset();
  endtask

  task automatic test_reset_mid_fetch();
    int sz;
    clear_logs();
    i_line_valid = 1'b1;
    i_fetch_target = 1'b1;
    i_fetch_valid = 1'b1;
    step();
    i_fetch_valid = 1'b0;
    for (int i = 0; i < 400 && sent < 200; i++) step();
    n_cmp++; if (sent != 200) begin n_bad++; $display("FAIL midrst_reach got %0d beats want 200", sent); end
    #2 i_reset_n = 1'b0;
    #1;
    n_cmp++; if ({o_wr_en, o_left_exp_aligned_wr_en, o_right_exp_aligned_wr_en, o_done} !== 4'b0000) begin
      n_bad++; $display("FAIL midrst_enables got %b want 0000",
                        {o_wr_en, o_left_exp_aligned_wr_en, o_right_exp_aligned_wr_en, o_done});
    end
    n_cmp++; if (o_busy !== 1'b0 || o_fetch_ready !== 1'b1 || o_line_ready !== 1'b0) begin
      n_bad++; $display("FAIL midrst_idle busy %b ready %b line_ready %b want 0 1 0", o_busy, o_fetch_ready, o_line_ready);
    end
    sz = wr_q.size() + left_q.size() + right_q.size();
    repeat (3) step();
    n_cmp++; if (wr_q.size() + left_q.size() + right_q.size() != sz) begin
      n_bad++; $display("FAIL midrst_no_writes got %0d logged writes want %0d", wr_q.size() + left_q.size() + right_q.size(), sz);
    end
    i_reset_n = 1'b1;
    clear_logs();
    i_fetch_valid = 1'b1;
    i_fetch_target = 1'b0;
    step();
    i_fetch_valid = 1'b0;
    repeat (5) step();
    n_cmp++; if (wr_q.size() == 0 || wr_q[0].addr != 0 || wr_q[0].data !== '0 || wr_q[0].tgt !== 1'b0) begin
      n_bad++; $display("FAIL midrst_restart writes %0d first addr %0d want >0 and 0",
                        wr_q.size(), (wr_q.size() > 0) ? wr_q[0].addr : -1);
    end
    i_line_valid = 1'b0;
    pulse_reset();
  endtask

  initial begin
    for (int s = 0; s < 2; s++)
      for (int l = 0; l < 16; l++)
        for (int b = 0; b < 32; b++)
          pmem[s][l][8*b +: 8] = exp_byte(s[0], l * 32 + b);
    i_reset_n = 1'b0;
    i_fetch_valid = 1'b0;
    i_fetch_target = 1'b0;
    i_line_valid = 1'b0;
    i_line_data = '0;
    test_reset();
    test_left_fetch();
    test_right_stalled();
    test_back_to_back();
    test_reset_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dispatcher_fetch_sequencer.md
DISPATCHER_FETCH_SEQUENCER -- requirements
Module: dispatcher_fetch_sequencer

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 256, line width in bits; EXP_LINES, default 16, packed-exponent lines per fetch; MAN_LINES, default 512, mantissa lines per fetch.
REQ-002 SHALL have ports:
- i_clk  in  1  sole clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_fetch_valid  in  1  fetch request.
- i_fetch_target  in  1  0=left, 1=right.
- o_fetch_ready  out  1  fetch request accepted.
- i_line_data  in  DATA_WIDTH  incoming line.
- i_line_valid  in  1  line handshake, valid side.
- o_line_ready  out  1  line handshake, ready side.
- o_wr_data  out  DATA_WIDTH  buffer write data.
- o_wr_addr  out  11  buffer write address.
- o_wr_en  out  1  buffer write enable.
- o_wr_target  out  1  buffer write side.
- o_exp_packed_rd_addr  out  4  packed-exponent read address.
- o_exp_packed_rd_target  out  1  packed-exponent read side.
- i_exp_packed_rd_data  in  DATA_WIDTH  packed-exponent read data (combinational read).
- o_left_exp_aligned_wr_addr  out  9.
- o_left_exp_aligned_wr_data  out  8.
- o_left_exp_aligned_wr_en  out  1.
- o_right_exp_aligned_wr_addr  out  9.
- o_right_exp_aligned_wr_data  out  8.
- o_right_exp_aligned_wr_en  out  1.
- o_busy  out  1  fetch in progress.
- o_done  out  1  one-cycle completion pulse.
REQ-003 The block SHALL use one clock, i_clk; reset i_reset_n is asynchronous and active-low.

Function
REQ-004 States SHALL be IDLE, EXP, MAN, DONE.
REQ-005 In IDLE, o_fetch_ready=1. A fetch is accepted when i_fetch_valid & o_fetch_ready. On acceptance, latch the target, clear counters and go to EXP. o_fetch_ready SHALL be 0 in every other state.
REQ-006 o_line_ready SHALL be 1 only in EXP, and in MAN while the mantissa count is below MAN_LINES. A beat is accepted when i_line_valid & o_line_ready.
REQ-007 Beat n (n=0..EXP_LINES+MAN_LINES-1) SHALL produce o_wr_en=1, o_wr_addr=n, o_wr_data=beat, and o_wr_target=latched target. These outputs are registered, with 1-cycle latency from acceptance. o_wr_en=0 when no beat is accepted.
REQ-008 Acceptance of beat EXP_LINES-1 SHALL move EXP to MAN.
REQ-009 Unpack counter k (9-bit, 0..511) SHALL start advancing two cycles after MAN entry and advance one per cycle, independent of line stalls.
REQ-010 For each k:
- o_exp_packed_rd_addr=k[8:5] and o_exp_packed_rd_target=latched target.
- Selected byte = i_exp_packed_rd_data[8*k[4:0]+7 : 8*k[4:0]].
- The aligned write (addr=k, data=byte, en=1) SHALL be registered, 1 cycle later, on the latched side's port only. The other side's enable SHALL stay 0.
REQ-011 The unpack stream SHALL be exactly 512 writes, strictly ascending, with no repeats or gaps.
REQ-012 MAN SHALL go to DONE once the final mantissa write has been issued and the final aligned write has been issued, whichever occurs later.
REQ-013 DONE SHALL last exactly one cycle, with o_done=1, then return to IDLE. A new fetch is acceptable the following cycle.
REQ-014 o_busy=1 in EXP, MAN and DONE; o_busy=0 in IDLE.
REQ-015 Beat counter width SHALL be 11 bits with no wrap. Beats presented after the final beat SHALL NOT be accepted.
REQ-016 i_fetch_valid asserted while busy SHALL be held off (not dropped or queued).

Reset
REQ-017 Reset SHALL force IDLE and clear all counters and the latched target. All outputs SHALL be 0 except o_fetch_ready=1.
REQ-018 Reset asserted mid-fetch SHALL abort immediately with no further writes. The next fetch after release SHALL restart at beat 0.

Structure
REQ-019 The state enum, EXP_LINES, MAN_LINES, and the exponent-index/byte-select widths SHALL live in a shared package, dispatcher_pkg.
REQ-020 A sub-module, exp_unpacker, SHALL own counter k and the byte select and the aligned-write registers. It SHALL take start and target inputs and produce a done output.

Verification
REQ-021 Left fetch, 528 back-to-back beats with data=beat index: wr_addr 0..527 in order; 512 left aligned writes with addr=k and data=k[7:0] when packed byte k=k; no right writes; o_done exactly once, 1 cycle after the final write.
REQ-022 Right fetch, i_line_valid toggling 1/0 during MAN: unpack completes in 512 consecutive cycles; mantissa writes gapped; o_done only after beat 527 is written.
REQ-023 Fetch request held during a busy fetch: o_fetch_ready=0 until the cycle after o_done; second fetch accepted then; wr_addr restarts at 0.
REQ-024 Reset asserted at beat 200: all enables 0 in the same cycle; state IDLE; next fetch begins at wr_addr 0.
REQ-025 Packed line 3 byte 31 = 0xA5: aligned write addr 127 data 0xA5. Packed line 15 byte 0 = 0x3C: addr 480 data 0x3C.
REQ-026 Extra beats offered after beat 527: o_line_ready=0 and no extra writes.
